// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file: packed-field
// extraction and write-port collision resolution.
package reg_file_pkg;

   localparam int MAX_RD      = 4;
   localparam int MAX_WR      = 2;
   localparam int MAX_FIELD_W = 64;
   localparam int MAX_VEC_W   = MAX_RD * MAX_FIELD_W;
   localparam int MAX_ADDR_W  = 16;
   localparam int WR_IDX_W    = $clog2(MAX_WR);

   typedef struct packed {
      logic                hit;
      logic [WR_IDX_W-1:0] idx;
   } wr_hit_t;

   function automatic logic [MAX_FIELD_W-1:0] get_field(input logic [MAX_VEC_W-1:0] vec,
                                                        input int k,
                                                        input int width);
      logic [MAX_VEC_W-1:0] shifted;
      shifted = vec >> (k * width);
      shifted = shifted & ~({MAX_VEC_W{1'b1}} << width);
      return shifted[MAX_FIELD_W-1:0];
   endfunction

   // Later ports override earlier ones, so the highest-index match wins.
   function automatic wr_hit_t resolve_write(input logic [MAX_WR-1:0]                 wr_en,
                                             input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr,
                                             input logic [MAX_ADDR_W-1:0]             target);
      wr_hit_t res;
      res = '0;
      for (int w = 0; w < MAX_WR; w++) begin
         if (wr_en[w] && (wr_addr[w] == target)) begin
            res.hit = 1'b1;
            res.idx = WR_IDX_W'(w);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface reg_file_mp_if #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 5,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1
);
   logic                          i_clear;
   logic [NUM_RD-1:0]             i_rd_en;
   logic [NUM_RD*ADDR_SIZE-1:0]   i_rd_addr;
   logic [NUM_WR-1:0]             i_wr_en;
   logic [NUM_WR*ADDR_SIZE-1:0]   i_wr_addr;
   logic [NUM_WR*WORD_SIZE-1:0]   i_wr_data;
   logic [NUM_RD*WORD_SIZE-1:0]   o_rd_data;
   logic [NUM_RD-1:0]             o_rd_valid;
   logic                          o_addr_err;

   modport master (
      output i_clear, i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
      input  o_rd_data, o_rd_valid, o_addr_err
   );

   modport slave (
      input  i_clear, i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
      output o_rd_data, o_rd_valid, o_addr_err
   );
endinterface

// File: rtl/reg_file_mp_rd_port.sv
// One read port: picks zero / bypass / stored data and registers it with a
// one-cycle valid flag.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 5,
   parameter int DEPTH     = 32,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_clear,
   input  logic                        i_rd_en,
   input  logic [ADDR_SIZE-1:0]        i_rd_addr,
   input  logic [WORD_SIZE-1:0]        i_stored,
   input  logic [NUM_WR-1:0]           i_wr_ok,
   input  logic [NUM_WR*ADDR_SIZE-1:0] i_wr_addr,
   input  logic [NUM_WR*WORD_SIZE-1:0] i_wr_data,
   output logic [WORD_SIZE-1:0]        o_rd_data,
   output logic                        o_rd_valid,
   output logic                        o_rd_err
);

   logic [MAX_WR-1:0]                 wr_en_ext;
   logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr_ext;
   logic [WORD_SIZE-1:0]              wr_data_ext [MAX_WR];
   wr_hit_t                           hit;
   logic                              in_range;
   logic [WORD_SIZE-1:0]              sel_data;

   always_comb begin
      wr_en_ext   = '0;
      wr_addr_ext = '0;
      for (int w = 0; w < MAX_WR; w++) wr_data_ext[w] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_en_ext[w]   = i_wr_ok[w];
         wr_addr_ext[w] = MAX_ADDR_W'(get_field(MAX_VEC_W'(i_wr_addr), w, ADDR_SIZE));
         wr_data_ext[w] = WORD_SIZE'(get_field(MAX_VEC_W'(i_wr_data), w, WORD_SIZE));
      end
      hit = resolve_write(wr_en_ext, wr_addr_ext, MAX_ADDR_W'(i_rd_addr));
   end

   // Zero register beats range error, which beats clear, which beats bypass.
   always_comb begin
      in_range = (int'(i_rd_addr) < DEPTH);
      sel_data = i_stored;
      if ((ZERO_REG != 0) && (i_rd_addr == '0))
         sel_data = '0;
      else if (!in_range)
         sel_data = '0;
      else if ((BYPASS != 0) && i_clear)
         sel_data = '0;
      else if ((BYPASS != 0) && hit.hit)
         sel_data = wr_data_ext[hit.idx];
   end

   assign o_rd_err = i_rd_en && !in_range;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) o_rd_data <= sel_data;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: storage, write decode and collision
// handling live here; each read port is a reg_file_rd_port instance.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 5,
   parameter int DEPTH     = 32,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   reg_file_mp_if.slave  bus
);

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr_arr [NUM_WR];
   logic [WORD_SIZE-1:0] wr_data_arr [NUM_WR];
   logic [NUM_WR-1:0]    wr_ok;
   logic [NUM_WR-1:0]    wr_err;
   logic [WORD_SIZE-1:0] rd_data_arr [NUM_RD];
   logic                 rd_valid_arr [NUM_RD];
   logic                 rd_err_arr [NUM_RD];
   logic [NUM_RD-1:0]    rd_err_vec;

   // A write only lands when in range and not aimed at the hardwired zero.
   always_comb begin
      wr_ok  = '0;
      wr_err = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_addr_arr[w] = ADDR_SIZE'(get_field(MAX_VEC_W'(bus.i_wr_addr), w, ADDR_SIZE));
         wr_data_arr[w] = WORD_SIZE'(get_field(MAX_VEC_W'(bus.i_wr_data), w, WORD_SIZE));
         wr_err[w] = bus.i_wr_en[w] && !(int'(wr_addr_arr[w]) < DEPTH);
         wr_ok[w]  = bus.i_wr_en[w] && (int'(wr_addr_arr[w]) < DEPTH) &&
                     !((ZERO_REG != 0) && (wr_addr_arr[w] == '0));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else if (bus.i_clear) begin
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++)
            if (wr_ok[w]) mem[wr_addr_arr[w]] <= wr_data_arr[w];
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_SIZE-1:0] rd_addr;
      logic [WORD_SIZE-1:0] stored;

      assign rd_addr = bus.i_rd_addr[r*ADDR_SIZE +: ADDR_SIZE];
      assign stored  = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

      reg_file_rd_port #(
         .WORD_SIZE (WORD_SIZE),
         .ADDR_SIZE (ADDR_SIZE),
         .DEPTH     (DEPTH),
         .NUM_WR    (NUM_WR),
         .ZERO_REG  (ZERO_REG),
         .BYPASS    (BYPASS)
      ) u_rd (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_clear    (bus.i_clear),
         .i_rd_en    (bus.i_rd_en[r]),
         .i_rd_addr  (rd_addr),
         .i_stored   (stored),
         .i_wr_ok    (wr_ok),
         .i_wr_addr  (bus.i_wr_addr),
         .i_wr_data  (bus.i_wr_data),
         .o_rd_data  (rd_data_arr[r]),
         .o_rd_valid (rd_valid_arr[r]),
         .o_rd_err   (rd_err_arr[r])
      );
   end

   always_comb begin
      bus.o_rd_data  = '0;
      bus.o_rd_valid = '0;
      rd_err_vec     = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         bus.o_rd_data[r*WORD_SIZE +: WORD_SIZE] = rd_data_arr[r];
         bus.o_rd_valid[r] = rd_valid_arr[r];
         rd_err_vec[r]     = rd_err_arr[r];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) bus.o_addr_err <= 1'b0;
      else        bus.o_addr_err <= (|wr_err) || (|rd_err_vec);
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three configurations share clock and reset.
module tb_reg_file_mp;

   logic i_clk;
   logic i_rst;
   int   checks;
   int   errors;

   reg_file_mp_if #(.WORD_SIZE(32), .ADDR_SIZE(5), .NUM_RD(2), .NUM_WR(1)) bus_d ();
   reg_file_mp_if #(.WORD_SIZE(32), .ADDR_SIZE(5), .NUM_RD(2), .NUM_WR(1)) bus_z ();
   reg_file_mp_if #(.WORD_SIZE(32), .ADDR_SIZE(5), .NUM_RD(2), .NUM_WR(2)) bus_c ();

   reg_file_mp #(.WORD_SIZE(32), .ADDR_SIZE(5), .DEPTH(32), .NUM_RD(2), .NUM_WR(1),
                 .ZERO_REG(1), .BYPASS(1))
      u_def (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_d));

   reg_file_mp #(.WORD_SIZE(32), .ADDR_SIZE(5), .DEPTH(32), .NUM_RD(2), .NUM_WR(1),
                 .ZERO_REG(0), .BYPASS(0))
      u_nz (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_z));

   reg_file_mp #(.WORD_SIZE(32), .ADDR_SIZE(5), .DEPTH(24), .NUM_RD(2), .NUM_WR(2),
                 .ZERO_REG(1), .BYPASS(1))
      u_col (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_c));

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idleAll();
      bus_d.i_clear = 1'b0; bus_d.i_rd_en = '0; bus_d.i_wr_en = '0;
      bus_z.i_clear = 1'b0; bus_z.i_rd_en = '0; bus_z.i_wr_en = '0;
      bus_c.i_clear = 1'b0; bus_c.i_rd_en = '0; bus_c.i_wr_en = '0;
   endtask

   initial begin
      logic [63:0] exp_lo;
      logic [63:0] exp_hi;
      checks = 0;
      errors = 0;
      i_rst  = 1'b0;
      idleAll();
      bus_d.i_rd_addr = '0; bus_d.i_wr_addr = '0; bus_d.i_wr_data = '0;
      bus_z.i_rd_addr = '0; bus_z.i_wr_addr = '0; bus_z.i_wr_data = '0;
      bus_c.i_rd_addr = '0; bus_c.i_wr_addr = '0; bus_c.i_wr_data = '0;
      repeat (2) applyStimulus();

      checkOutput("reset_data",  64'(bus_d.o_rd_data), 64'h0);
      checkOutput("reset_valid", 64'(bus_d.o_rd_valid), 64'h0);
      checkOutput("reset_err",   64'(bus_d.o_addr_err), 64'h0);
      i_rst = 1'b1;

      // Basic write then read, followed by a mid-stream reset.
      bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'd5; bus_d.i_wr_data = 32'hDEADBEEF;
      applyStimulus();
      bus_d.i_wr_en = 1'b0;
      bus_d.i_rd_en = 2'b01; bus_d.i_rd_addr = {5'd0, 5'd5};
      applyStimulus();
      checkOutput("basic_rd_data",  64'(bus_d.o_rd_data[31:0]), 64'hDEADBEEF);
      checkOutput("basic_rd_valid", 64'(bus_d.o_rd_valid), 64'h1);
      #2 i_rst = 1'b0;
      #1;
      checkOutput("midrst_data",  64'(bus_d.o_rd_data), 64'h0);
      checkOutput("midrst_valid", 64'(bus_d.o_rd_valid), 64'h0);
      #2 i_rst = 1'b1;
      applyStimulus();
      checkOutput("post_rst_r5",    64'(bus_d.o_rd_data[31:0]), 64'h0);
      checkOutput("post_rst_valid", 64'(bus_d.o_rd_valid), 64'h1);

      // Register 0: hardwired vs ordinary.
      idleAll();
      bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'd0; bus_d.i_wr_data = 32'h12345678;
      bus_z.i_wr_en = 1'b1; bus_z.i_wr_addr = 5'd0; bus_z.i_wr_data = 32'h12345678;
      applyStimulus();
      bus_d.i_wr_en = 1'b0; bus_d.i_rd_en = 2'b01; bus_d.i_rd_addr = '0;
      bus_z.i_wr_en = 1'b0; bus_z.i_rd_en = 2'b01; bus_z.i_rd_addr = '0;
      applyStimulus();
      checkOutput("zero_reg_on",  64'(bus_d.o_rd_data[31:0]), 64'h0);
      checkOutput("zero_reg_off", 64'(bus_z.o_rd_data[31:0]), 64'h12345678);

      // Same-cycle write and read of r7 on port 1.
      idleAll();
      bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'd7; bus_d.i_wr_data = 32'hA5A5A5A5;
      bus_d.i_rd_en = 2'b10; bus_d.i_rd_addr = {5'd7, 5'd0};
      bus_z.i_wr_en = 1'b1; bus_z.i_wr_addr = 5'd7; bus_z.i_wr_data = 32'hA5A5A5A5;
      bus_z.i_rd_en = 2'b10; bus_z.i_rd_addr = {5'd7, 5'd0};
      applyStimulus();
      checkOutput("bypass_on",  64'(bus_d.o_rd_data[63:32]), 64'hA5A5A5A5);
      checkOutput("bypass_off", 64'(bus_z.o_rd_data[63:32]), 64'h0);
      checkOutput("bypass_valid", 64'(bus_d.o_rd_valid), 64'h2);
      bus_d.i_wr_en = 1'b0; bus_z.i_wr_en = 1'b0;
      applyStimulus();
      checkOutput("bypass_off_next", 64'(bus_z.o_rd_data[63:32]), 64'hA5A5A5A5);

      // Two write ports hit r3 together; port 1 must win.
      idleAll();
      bus_c.i_wr_en = 2'b11; bus_c.i_wr_addr = {5'd3, 5'd3};
      bus_c.i_wr_data = {32'h2, 32'h1};
      bus_c.i_rd_en = 2'b01; bus_c.i_rd_addr = {5'd0, 5'd3};
      applyStimulus();
      checkOutput("collision_bypass", 64'(bus_c.o_rd_data[31:0]), 64'h2);
      bus_c.i_wr_en = 2'b00;
      applyStimulus();
      checkOutput("collision_stored", 64'(bus_c.o_rd_data[31:0]), 64'h2);

      // Out-of-range accesses with DEPTH=24.
      idleAll();
      bus_c.i_wr_en = 2'b01; bus_c.i_wr_addr = {5'd0, 5'd30};
      bus_c.i_wr_data = {32'h0, 32'hFF};
      applyStimulus();
      checkOutput("range_wr_err", 64'(bus_c.o_addr_err), 64'h1);
      idleAll();
      applyStimulus();
      checkOutput("range_err_clears", 64'(bus_c.o_addr_err), 64'h0);
      bus_c.i_rd_en = 2'b01; bus_c.i_rd_addr = {5'd0, 5'd30};
      applyStimulus();
      checkOutput("range_rd_data",  64'(bus_c.o_rd_data[31:0]), 64'h0);
      checkOutput("range_rd_err",   64'(bus_c.o_addr_err), 64'h1);
      checkOutput("range_rd_valid", 64'(bus_c.o_rd_valid), 64'h1);
      for (int a = 0; a < 24; a += 2) begin
         bus_c.i_rd_en = 2'b11;
         bus_c.i_rd_addr = {5'(a + 1), 5'(a)};
         applyStimulus();
         exp_lo = (a == 3)     ? 64'h2 : 64'h0;
         exp_hi = (a + 1 == 3) ? 64'h2 : 64'h0;
         checkOutput("range_keep_lo", 64'(bus_c.o_rd_data[31:0]),  exp_lo);
         checkOutput("range_keep_hi", 64'(bus_c.o_rd_data[63:32]), exp_hi);
      end
      checkOutput("range_keep_err", 64'(bus_c.o_addr_err), 64'h0);

      // Fill r1..r4, then clear with a competing write to r2.
      idleAll();
      for (int i = 1; i <= 4; i++) begin
         bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'(i); bus_d.i_wr_data = 32'h100 + 32'(i);
         applyStimulus();
      end
      bus_d.i_wr_en = 1'b0;
      bus_d.i_rd_en = 2'b11; bus_d.i_rd_addr = {5'd4, 5'd2};
      applyStimulus();
      checkOutput("fill_r2", 64'(bus_d.o_rd_data[31:0]),  64'h102);
      checkOutput("fill_r4", 64'(bus_d.o_rd_data[63:32]), 64'h104);
      bus_d.i_clear = 1'b1;
      bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'd2; bus_d.i_wr_data = 32'h9;
      applyStimulus();
      checkOutput("clear_same_r2", 64'(bus_d.o_rd_data[31:0]),  64'h0);
      checkOutput("clear_same_r4", 64'(bus_d.o_rd_data[63:32]), 64'h0);
      bus_d.i_clear = 1'b0; bus_d.i_wr_en = 1'b0;
      bus_d.i_rd_addr = {5'd3, 5'd1};
      applyStimulus();
      checkOutput("clear_r1", 64'(bus_d.o_rd_data[31:0]),  64'h0);
      checkOutput("clear_r3", 64'(bus_d.o_rd_data[63:32]), 64'h0);
      bus_d.i_rd_addr = {5'd4, 5'd2};
      applyStimulus();
      checkOutput("clear_r2", 64'(bus_d.o_rd_data[31:0]),  64'h0);
      checkOutput("clear_r4", 64'(bus_d.o_rd_data[63:32]), 64'h0);

      // Load distinct values, then hold outputs with reads disabled.
      bus_d.i_rd_en = 2'b00;
      bus_d.i_wr_en = 1'b1; bus_d.i_wr_addr = 5'd1; bus_d.i_wr_data = 32'h55;
      applyStimulus();
      bus_d.i_wr_addr = 5'd2; bus_d.i_wr_data = 32'h66;
      applyStimulus();
      bus_d.i_wr_en = 1'b0;
      bus_d.i_rd_en = 2'b11; bus_d.i_rd_addr = {5'd2, 5'd1};
      applyStimulus();
      checkOutput("hold_load", 64'(bus_d.o_rd_data), {32'h66, 32'h55});
      bus_d.i_rd_en = 2'b00; bus_d.i_rd_addr = {5'd4, 5'd3};
      for (int c = 0; c < 3; c++) begin
         applyStimulus();
         checkOutput("hold_data",  64'(bus_d.o_rd_data), {32'h66, 32'h55});
         checkOutput("hold_valid", 64'(bus_d.o_rd_valid), 64'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
